// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation-station issue queue with CDB wakeup and registered issue port
module rs_issue_queue #(
    parameter int RS_NUM = 4,
    parameter int RS_SEL = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int OP_W   = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_dispatch_vld,
    output logic              o_dispatch_rdy,
    input  logic [OP_W-1:0]   i_dispatch_op,
    input  logic [TAG_W-1:0]  i_dispatch_dst_tag,
    input  logic              i_dispatch_src1_rdy,
    input  logic [TAG_W-1:0]  i_dispatch_src1_tag,
    input  logic [DATA_W-1:0] i_dispatch_src1_data,
    input  logic              i_dispatch_src2_rdy,
    input  logic [TAG_W-1:0]  i_dispatch_src2_tag,
    input  logic [DATA_W-1:0] i_dispatch_src2_data,
    input  logic              i_cdb_vld,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic [RS_NUM-1:0] o_req,
    input  logic              i_ack_vld,
    input  logic [RS_SEL-1:0] i_ack,
    input  logic              i_fu_rdy,
    output logic              o_issue_vld,
    output logic [OP_W-1:0]   o_issue_op,
    output logic [TAG_W-1:0]  o_issue_dst_tag,
    output logic [DATA_W-1:0] o_issue_src1_data,
    output logic [DATA_W-1:0] o_issue_src2_data
);

    logic [RS_NUM-1:0] valid_q, valid_d;
    logic [RS_NUM-1:0] src1_rdy_q, src1_rdy_d;
    logic [RS_NUM-1:0] src2_rdy_q, src2_rdy_d;
    logic [OP_W-1:0]   op_q        [RS_NUM];
    logic [OP_W-1:0]   op_d        [RS_NUM];
    logic [TAG_W-1:0]  dst_tag_q   [RS_NUM];
    logic [TAG_W-1:0]  dst_tag_d   [RS_NUM];
    logic [TAG_W-1:0]  src1_tag_q  [RS_NUM];
    logic [TAG_W-1:0]  src1_tag_d  [RS_NUM];
    logic [TAG_W-1:0]  src2_tag_q  [RS_NUM];
    logic [TAG_W-1:0]  src2_tag_d  [RS_NUM];
    logic [DATA_W-1:0] src1_data_q [RS_NUM];
    logic [DATA_W-1:0] src1_data_d [RS_NUM];
    logic [DATA_W-1:0] src2_data_q [RS_NUM];
    logic [DATA_W-1:0] src2_data_d [RS_NUM];

    logic              issue_vld_q, issue_vld_d;
    logic [OP_W-1:0]   issue_op_q, issue_op_d;
    logic [TAG_W-1:0]  issue_dst_tag_q, issue_dst_tag_d;
    logic [DATA_W-1:0] issue_src1_data_q, issue_src1_data_d;
    logic [DATA_W-1:0] issue_src2_data_q, issue_src2_data_d;

    logic [RS_SEL-1:0] alloc_idx;
    logic              alloc_found;
    logic              dispatch_fire;
    logic              issue_fire;

    // Lowest-index free slot, taken from the registered valid vector so a slot freed by issue waits a cycle
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < RS_NUM; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_idx   = RS_SEL'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign o_dispatch_rdy    = alloc_found;
    assign o_req             = valid_q & src1_rdy_q & src2_rdy_q;
    assign dispatch_fire     = i_dispatch_vld & o_dispatch_rdy;
    assign issue_fire        = i_ack_vld & i_fu_rdy & o_req[i_ack];

    assign o_issue_vld       = issue_vld_q;
    assign o_issue_op        = issue_op_q;
    assign o_issue_dst_tag   = issue_dst_tag_q;
    assign o_issue_src1_data = issue_src1_data_q;
    assign o_issue_src2_data = issue_src2_data_q;

    // Next state: wakeup, then issue, then dispatch into a free slot; flush overrides everything
    always_comb begin
        valid_d           = valid_q;
        src1_rdy_d        = src1_rdy_q;
        src2_rdy_d        = src2_rdy_q;
        op_d              = op_q;
        dst_tag_d         = dst_tag_q;
        src1_tag_d        = src1_tag_q;
        src2_tag_d        = src2_tag_q;
        src1_data_d       = src1_data_q;
        src2_data_d       = src2_data_q;
        issue_vld_d       = 1'b0;
        issue_op_d        = issue_op_q;
        issue_dst_tag_d   = issue_dst_tag_q;
        issue_src1_data_d = issue_src1_data_q;
        issue_src2_data_d = issue_src2_data_q;

        for (int i = 0; i < RS_NUM; i++) begin
            if (valid_q[i] && i_cdb_vld) begin
                if (!src1_rdy_q[i] && (src1_tag_q[i] == i_cdb_tag)) begin
                    src1_rdy_d[i]  = 1'b1;
                    src1_data_d[i] = i_cdb_data;
                end
                if (!src2_rdy_q[i] && (src2_tag_q[i] == i_cdb_tag)) begin
                    src2_rdy_d[i]  = 1'b1;
                    src2_data_d[i] = i_cdb_data;
                end
            end
        end

        // Issue reads registered payload; a requesting entry has no waiting source to wake
        if (issue_fire) begin
            issue_vld_d       = 1'b1;
            issue_op_d        = op_q[i_ack];
            issue_dst_tag_d   = dst_tag_q[i_ack];
            issue_src1_data_d = src1_data_q[i_ack];
            issue_src2_data_d = src2_data_q[i_ack];
            valid_d[i_ack]    = 1'b0;
        end

        // Waiting sources keep CDB data as filler; it is overwritten on wakeup
        if (dispatch_fire) begin
            valid_d[alloc_idx]     = 1'b1;
            op_d[alloc_idx]        = i_dispatch_op;
            dst_tag_d[alloc_idx]   = i_dispatch_dst_tag;
            src1_rdy_d[alloc_idx]  = i_dispatch_src1_rdy | (i_cdb_vld & (i_cdb_tag == i_dispatch_src1_tag));
            src1_tag_d[alloc_idx]  = i_dispatch_src1_tag;
            src1_data_d[alloc_idx] = i_dispatch_src1_rdy ? i_dispatch_src1_data : i_cdb_data;
            src2_rdy_d[alloc_idx]  = i_dispatch_src2_rdy | (i_cdb_vld & (i_cdb_tag == i_dispatch_src2_tag));
            src2_tag_d[alloc_idx]  = i_dispatch_src2_tag;
            src2_data_d[alloc_idx] = i_dispatch_src2_rdy ? i_dispatch_src2_data : i_cdb_data;
        end

        if (i_flush) begin
            valid_d           = '0;
            issue_vld_d       = 1'b0;
            issue_op_d        = '0;
            issue_dst_tag_d   = '0;
            issue_src1_data_d = '0;
            issue_src2_data_d = '0;
        end
    end

    // Control state and issue register; reset empties the queue and zeroes the issue port
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q           <= '0;
            src1_rdy_q        <= '0;
            src2_rdy_q        <= '0;
            issue_vld_q       <= 1'b0;
            issue_op_q        <= '0;
            issue_dst_tag_q   <= '0;
            issue_src1_data_q <= '0;
            issue_src2_data_q <= '0;
        end else begin
            valid_q           <= valid_d;
            src1_rdy_q        <= src1_rdy_d;
            src2_rdy_q        <= src2_rdy_d;
            issue_vld_q       <= issue_vld_d;
            issue_op_q        <= issue_op_d;
            issue_dst_tag_q   <= issue_dst_tag_d;
            issue_src1_data_q <= issue_src1_data_d;
            issue_src2_data_q <= issue_src2_data_d;
        end
    end

    // Entry payload; only meaningful while the entry's valid bit is set
    always_ff @(posedge i_clk) begin
        op_q        <= op_d;
        dst_tag_q   <= dst_tag_d;
        src1_tag_q  <= src1_tag_d;
        src2_tag_q  <= src2_tag_d;
        src1_data_q <= src1_data_d;
        src2_data_q <= src2_data_d;
    end

endmodule
